// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared widths, FSM encodings and payload types for the DE/AGEX issue controller.
package pipe_hazard_ctrl_pkg;

    localparam int unsigned DBITS     = 32;
    localparam int unsigned REGNOBITS = 5;
    localparam int unsigned NUM_REGS  = 32;
    localparam int unsigned CNT_W     = 2;

    localparam logic [1:0] HZ_RUN      = 2'd0;
    localparam logic [1:0] HZ_BR_WAIT  = 2'd1;
    localparam logic [1:0] HZ_REDIRECT = 2'd2;

    // Redirect request towards FE
    typedef struct packed {
        logic             redirect;
        logic [DBITS-1:0] pc;
    } hz_fe_t;

    // Control towards DE
    typedef struct packed {
        logic stall;
        logic flush;
    } hz_de_t;

    localparam int unsigned from_HZ_to_FE_WIDTH = $bits(hz_fe_t);
    localparam int unsigned from_HZ_to_DE_WIDTH = $bits(hz_de_t);

    // A source operand is blocked when it is read, is not x0 and has a writer in flight
    function automatic logic src_busy(input logic                 used,
                                      input logic [REGNOBITS-1:0] idx,
                                      input logic [NUM_REGS-1:0]  busy);
        return used && (idx != '0) && busy[idx];
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// DE / AGEX / WB / FE signal bundle around the issue controller.
interface pipe_hazard_ctrl_if;
    import pipe_hazard_ctrl_pkg::*;

    logic                 de_valid;
    logic [REGNOBITS-1:0] de_rs1;
    logic                 de_rs1_used;
    logic [REGNOBITS-1:0] de_rs2;
    logic                 de_rs2_used;
    logic [REGNOBITS-1:0] de_rd;
    logic                 de_wr_reg;
    logic                 de_is_branch;
    logic                 issue_stall;
    logic                 agex_br_resolve;
    logic                 agex_br_taken;
    logic [DBITS-1:0]     agex_br_target;
    logic                 fe_redirect;
    logic [DBITS-1:0]     fe_redirect_pc;
    logic                 de_flush;
    logic                 wb_valid;
    logic                 wb_wr_reg;
    logic [REGNOBITS-1:0] wb_rd;
    logic [NUM_REGS-1:0]  busy_vec;
    logic                 sb_err;

    // Pipeline side
    modport master (
        output de_valid, de_rs1, de_rs1_used, de_rs2, de_rs2_used, de_rd, de_wr_reg,
               de_is_branch, agex_br_resolve, agex_br_taken, agex_br_target,
               wb_valid, wb_wr_reg, wb_rd,
        input  issue_stall, fe_redirect, fe_redirect_pc, de_flush, busy_vec, sb_err
    );

    // Controller side
    modport slave (
        input  de_valid, de_rs1, de_rs1_used, de_rs2, de_rs2_used, de_rd, de_wr_reg,
               de_is_branch, agex_br_resolve, agex_br_taken, agex_br_target,
               wb_valid, wb_wr_reg, wb_rd,
        output issue_stall, fe_redirect, fe_redirect_pc, de_flush, busy_vec, sb_err
    );

endinterface

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// Counting scoreboard: one saturating in-flight counter per architectural register.
module hazard_scoreboard
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc_en,
    input  logic [REGNOBITS-1:0] inc_idx,
    input  logic                 dec_en,
    input  logic [REGNOBITS-1:0] dec_idx,
    output logic [NUM_REGS-1:0]  busy_vec,
    output logic                 sb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_d;
    logic                err_d;

    // Next counts; x0 is never tracked, overflow/underflow holds the count and flags an error
    always_comb begin
        cnt_d  = cnt_q;
        err_d  = sb_err;
        busy_d = '0;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if ((inc_en && inc_idx == REGNOBITS'(i)) && !(dec_en && dec_idx == REGNOBITS'(i))) begin
                if (cnt_q[i] == CNT_MAX) err_d = 1'b1;
                else                     cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if ((dec_en && dec_idx == REGNOBITS'(i)) && !(inc_en && inc_idx == REGNOBITS'(i))) begin
                if (cnt_q[i] == '0) err_d = 1'b1;
                else                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
            busy_d[i] = (cnt_d[i] != '0);
        end
        cnt_d[0] = '0;
    end

    // Counter, busy and sticky error registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '{default: '0};
            busy_vec <= '0;
            sb_err   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            busy_vec <= busy_d;
            sb_err   <= err_d;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// DE->AGEX issue controller: RAW stall, branch serialisation and taken-branch redirect/flush.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    pipe_hazard_ctrl_if.slave  bus
);

    logic [1:0]          state_q;
    logic [1:0]          state_d;
    hz_fe_t              fe_q;
    hz_de_t              de_c;
    logic                raw_c;
    logic                issue_c;
    logic [NUM_REGS-1:0] busy;
    logic                sb_err;

    // In-flight destination tracking
    hazard_scoreboard u_sb (
        .clk      (clk),
        .reset    (reset),
        .inc_en   (issue_c & bus.de_wr_reg),
        .inc_idx  (bus.de_rd),
        .dec_en   (bus.wb_valid & bus.wb_wr_reg),
        .dec_idx  (bus.wb_rd),
        .busy_vec (busy),
        .sb_err   (sb_err)
    );

    // Next state, stall and issue decision
    always_comb begin
        state_d    = state_q;
        de_c       = '0;
        de_c.flush = fe_q.redirect;
        raw_c      = src_busy(bus.de_rs1_used, bus.de_rs1, busy)
                   | src_busy(bus.de_rs2_used, bus.de_rs2, busy);
        case (state_q)
            HZ_RUN: begin
                de_c.stall = bus.de_valid & raw_c;
            end
            HZ_BR_WAIT: begin
                de_c.stall = 1'b1;
                if (bus.agex_br_resolve) state_d = bus.agex_br_taken ? HZ_REDIRECT : HZ_RUN;
            end
            HZ_REDIRECT: begin
                de_c.stall = 1'b1;
                state_d    = HZ_RUN;
            end
            default: begin
                de_c.stall = 1'b1;
                state_d    = HZ_RUN;
            end
        endcase
        issue_c = bus.de_valid & ~de_c.stall & ~de_c.flush;
        if (state_q == HZ_RUN && issue_c && bus.de_is_branch) state_d = HZ_BR_WAIT;
    end

    // State and FE redirect registers; redirect pulses for the single REDIRECT cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= HZ_RUN;
            fe_q    <= '0;
        end else begin
            state_q       <= state_d;
            fe_q.redirect <= (state_d == HZ_REDIRECT);
            if (state_q == HZ_BR_WAIT && bus.agex_br_resolve && bus.agex_br_taken)
                fe_q.pc <= bus.agex_br_target;
        end
    end

    assign bus.issue_stall    = de_c.stall;
    assign bus.de_flush       = de_c.flush;
    assign bus.fe_redirect    = fe_q.redirect;
    assign bus.fe_redirect_pc = fe_q.pc;
    assign bus.busy_vec       = busy;
    assign bus.sb_err         = sb_err;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: RAW stall, x0, taken/not-taken branch, saturation, reset.
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    pipe_hazard_ctrl_if hz();

    pipe_hazard_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (hz)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_de(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic wr, input logic br);
        hz.de_valid = v;  hz.de_rs1 = rs1; hz.de_rs1_used = u1;
        hz.de_rs2 = rs2;  hz.de_rs2_used = u2;
        hz.de_rd = rd;    hz.de_wr_reg = wr; hz.de_is_branch = br;
        #1;
    endtask

    task automatic set_wb(input logic v, input logic [4:0] rd);
        hz.wb_valid = v; hz.wb_wr_reg = v; hz.wb_rd = rd;
        #1;
    endtask

    task automatic set_br(input logic res, input logic tk, input logic [31:0] tgt);
        hz.agex_br_resolve = res; hz.agex_br_taken = tk; hz.agex_br_target = tgt;
        #1;
    endtask

    initial begin
        set_de(0, 0, 0, 0, 0, 0, 0, 0);
        set_wb(0, 0);
        set_br(0, 0, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_stall",    64'(hz.issue_stall),    64'h0);
        chk("rst_redirect", 64'(hz.fe_redirect),    64'h0);
        chk("rst_pc",       64'(hz.fe_redirect_pc), 64'h0);
        chk("rst_flush",    64'(hz.de_flush),       64'h0);
        chk("rst_busy",     64'(hz.busy_vec),       64'h0);
        chk("rst_err",      64'(hz.sb_err),         64'h0);

        // RAW on x5
        set_de(1, 0, 0, 0, 0, 5, 1, 0);
        chk("raw_first_issue", 64'(hz.issue_stall), 64'h0);
        tick();
        set_de(1, 5, 1, 0, 0, 6, 1, 0);
        chk("raw_busy5",   64'(hz.busy_vec[5]), 64'h1);
        chk("raw_stall_a", 64'(hz.issue_stall), 64'h1);
        tick();
        chk("raw_stall_b", 64'(hz.issue_stall), 64'h1);
        set_wb(1, 5);
        chk("raw_no_bypass", 64'(hz.issue_stall), 64'h1);
        tick();
        set_wb(0, 0);
        chk("raw_lift",     64'(hz.issue_stall), 64'h0);
        chk("raw_busy_clr", 64'(hz.busy_vec),    64'h0);
        tick();
        set_de(0, 0, 0, 0, 0, 0, 0, 0);
        chk("raw_issue6", 64'(hz.busy_vec), 64'h40);
        set_wb(1, 6);
        tick();
        set_wb(0, 0);
        chk("raw_ret6", 64'(hz.busy_vec), 64'h0);

        // x0 never tracked
        set_de(1, 0, 1, 0, 1, 0, 1, 0);
        chk("x0_stall_a", 64'(hz.issue_stall), 64'h0);
        tick();
        set_wb(1, 0);
        chk("x0_stall_b", 64'(hz.issue_stall), 64'h0);
        chk("x0_busy",    64'(hz.busy_vec),    64'h0);
        tick();
        set_wb(0, 0);
        set_de(0, 0, 0, 0, 0, 0, 0, 0);
        chk("x0_err",  64'(hz.sb_err),   64'h0);
        chk("x0_busy2", 64'(hz.busy_vec), 64'h0);

        // BEQ taken to 0x40
        set_de(1, 1, 1, 2, 1, 0, 0, 1);
        chk("beq_issue", 64'(hz.issue_stall), 64'h0);
        tick();
        set_de(1, 0, 0, 0, 0, 8, 1, 0);
        chk("beq_wait_stall", 64'(hz.issue_stall), 64'h1);
        tick();
        chk("beq_wait_stall2", 64'(hz.issue_stall), 64'h1);
        chk("beq_no_inc8",     64'(hz.busy_vec),    64'h0);
        set_br(1, 1, 32'h0000_0040);
        chk("beq_t_redirect", 64'(hz.fe_redirect), 64'h0);
        tick();
        set_br(0, 0, 32'h0);
        chk("beq_t1_redirect", 64'(hz.fe_redirect),    64'h1);
        chk("beq_t1_pc",       64'(hz.fe_redirect_pc), 64'h40);
        chk("beq_t1_flush",    64'(hz.de_flush),       64'h1);
        chk("beq_t1_stall",    64'(hz.issue_stall),    64'h1);
        tick();
        chk("beq_t2_redirect", 64'(hz.fe_redirect), 64'h0);
        chk("beq_t2_flush",    64'(hz.de_flush),    64'h0);
        chk("beq_t2_stall",    64'(hz.issue_stall), 64'h0);
        chk("beq_flushed_inc", 64'(hz.busy_vec),    64'h0);
        set_de(0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // BNE not taken
        set_de(1, 3, 1, 4, 1, 0, 0, 1);
        tick();
        set_de(1, 0, 0, 0, 0, 9, 1, 0);
        set_br(1, 0, 32'h0000_0080);
        chk("bne_t_stall", 64'(hz.issue_stall), 64'h1);
        tick();
        set_br(0, 0, 32'h0);
        chk("bne_t1_redirect", 64'(hz.fe_redirect),    64'h0);
        chk("bne_t1_flush",    64'(hz.de_flush),       64'h0);
        chk("bne_t1_stall",    64'(hz.issue_stall),    64'h0);
        chk("bne_t1_pc",       64'(hz.fe_redirect_pc), 64'h40);
        tick();
        set_de(0, 0, 0, 0, 0, 0, 0, 0);
        chk("bne_issue9", 64'(hz.busy_vec), 64'h200);
        // Resolve pulse while in RUN is ignored
        set_wb(1, 9);
        set_br(1, 1, 32'hDEAD_BEEF);
        tick();
        set_wb(0, 0);
        set_br(0, 0, 32'h0);
        chk("run_res_redirect", 64'(hz.fe_redirect),    64'h0);
        chk("run_res_pc",       64'(hz.fe_redirect_pc), 64'h40);
        chk("bne_ret9",         64'(hz.busy_vec),       64'h0);

        // Counter on x7: same-cycle inc+dec, then saturation
        set_de(1, 0, 0, 0, 0, 7, 1, 0);
        tick();
        set_wb(1, 7);
        tick();
        set_wb(0, 0);
        chk("sat_cnt1_busy", 64'(hz.busy_vec), 64'h80);
        tick();
        tick();
        chk("sat_cnt3_err", 64'(hz.sb_err), 64'h0);
        tick();
        set_de(0, 0, 0, 0, 0, 0, 0, 0);
        chk("sat_err", 64'(hz.sb_err), 64'h1);
        set_wb(1, 7);
        tick();
        tick();
        chk("sat_held_busy", 64'(hz.busy_vec), 64'h80);
        tick();
        set_wb(0, 0);
        chk("sat_drain",  64'(hz.busy_vec), 64'h0);
        chk("sat_sticky", 64'(hz.sb_err),   64'h1);

        // Reset in BR_WAIT with busy registers
        set_de(1, 0, 0, 0, 0, 10, 1, 0);
        tick();
        set_de(1, 0, 0, 0, 0, 1, 1, 1);
        tick();
        set_de(1, 0, 0, 0, 0, 11, 1, 0);
        chk("rbw_stall", 64'(hz.issue_stall), 64'h1);
        chk("rbw_busy",  64'(hz.busy_vec),    64'h402);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_de(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rbw_busy0",     64'(hz.busy_vec),       64'h0);
        chk("rbw_err0",      64'(hz.sb_err),         64'h0);
        chk("rbw_redirect0", 64'(hz.fe_redirect),    64'h0);
        chk("rbw_flush0",    64'(hz.de_flush),       64'h0);
        chk("rbw_pc0",       64'(hz.fe_redirect_pc), 64'h0);
        chk("rbw_stall0",    64'(hz.issue_stall),    64'h0);
        set_br(1, 1, 32'h0000_0100);
        tick();
        set_br(0, 0, 32'h0);
        chk("rbw_late_redirect", 64'(hz.fe_redirect),    64'h0);
        chk("rbw_late_pc",       64'(hz.fe_redirect_pc), 64'h0);
        set_de(1, 10, 1, 1, 1, 12, 1, 0);
        chk("rbw_run_nostall", 64'(hz.issue_stall), 64'h0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
